rf_plus_alu: RTL and testbench

- Datapath slice: 8 x 16-bit register file with two combinational read ports and one synchronous write port, feeding a 16-bit add/subtract ALU with Z/N/C/V flags.
- ALU operand A is always read port A. Operand B is either read port B or the zero-extended 5-bit immediate.
- Used as the execute core of the single-cycle RISC datapath.

---
 rtl/rf_plus_alu.sv | 79 +++++++
 tb/tb_rf_plus_alu.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/rf_plus_alu.sv
// 8 x 16-bit register file feeding a 16-bit add/subtract ALU with Z/N/C/V flags.
// Optional build macro RF_BYPASS_EN forwards same-cycle write data to the read ports.
module rf_plus_alu (
    input  logic        clk,
    input  logic        clr,
    input  logic [2:0]  Read_Addr_A,
    input  logic [2:0]  Read_Addr_B,
    input  logic [2:0]  Write_Addr,
    input  logic [15:0] Write_Data,
    input  logic        Write_En,
    input  logic        Pre_C,
    input  logic        Src_ALU_B,
    input  logic [4:0]  imm5,
    input  logic        ADC,
    input  logic        SUB,
    input  logic        SBB,
    output logic [15:0] OutA,
    output logic [15:0] OutB,
    output logic [15:0] Y,
    output logic        Z,
    output logic        N,
    output logic        C,
    output logic        V
);

    logic [15:0] regs_q [8];

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= 16'h0000;
            end
        end else if (Write_En) begin
            regs_q[Write_Addr] <= Write_Data;
        end
    end

`ifdef RF_BYPASS_EN
    logic fwd_a, fwd_b;

    assign fwd_a = Write_En && !clr && (Read_Addr_A == Write_Addr);
    assign fwd_b = Write_En && !clr && (Read_Addr_B == Write_Addr);
    assign OutA  = fwd_a ? Write_Data : regs_q[Read_Addr_A];
    assign OutB  = fwd_b ? Write_Data : regs_q[Read_Addr_B];
`else
    assign OutA = regs_q[Read_Addr_A];
    assign OutB = regs_q[Read_Addr_B];
`endif

    logic [15:0] b_sel;
    logic [15:0] b_x;
    logic        c_in;
    logic [16:0] sum;

    assign b_sel = Src_ALU_B ? {11'b0, imm5} : OutB;

    // Subtraction is A + ~B + cin; SBB inverts the incoming borrow so C=1 means no borrow.
    always_comb begin
        b_x  = b_sel;
        c_in = 1'b0;
        if (SBB) begin
            b_x  = ~b_sel;
            c_in = ~Pre_C;
        end else if (SUB) begin
            b_x  = ~b_sel;
            c_in = 1'b1;
        end else if (ADC) begin
            c_in = Pre_C;
        end
    end

    assign sum = {1'b0, OutA} + {1'b0, b_x} + {16'b0, c_in};
    assign Y   = sum[15:0];
    assign C   = sum[16];
    assign Z   = (sum[15:0] == 16'h0000);
    assign N   = sum[15];
    assign V   = (OutA[15] == b_x[15]) && (sum[15] != OutA[15]);

endmodule

// File: tb/tb_rf_plus_alu.sv
// Scoreboard bench for rf_plus_alu: expected outputs queued at drive time, compared after settling.
module tb_rf_plus_alu;

    logic        clk = 1'b0;
    logic        clr;
    logic [2:0]  Read_Addr_A, Read_Addr_B, Write_Addr;
    logic [15:0] Write_Data;
    logic        Write_En, Pre_C, Src_ALU_B, ADC, SUB, SBB;
    logic [4:0]  imm5;
    logic [15:0] OutA, OutB, Y;
    logic        Z, N, C, V;

    always #5 clk = ~clk;

    rf_plus_alu dut (
        .clk        (clk),
        .clr        (clr),
        .Read_Addr_A(Read_Addr_A),
        .Read_Addr_B(Read_Addr_B),
        .Write_Addr (Write_Addr),
        .Write_Data (Write_Data),
        .Write_En   (Write_En),
        .Pre_C      (Pre_C),
        .Src_ALU_B  (Src_ALU_B),
        .imm5       (imm5),
        .ADC        (ADC),
        .SUB        (SUB),
        .SBB        (SBB),
        .OutA       (OutA),
        .OutB       (OutB),
        .Y          (Y),
        .Z          (Z),
        .N          (N),
        .C          (C),
        .V          (V)
    );

    typedef struct packed {
        logic [15:0] outa;
        logic [15:0] outb;
        logic [15:0] y;
        logic        z;
        logic        n;
        logic        c;
        logic        v;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] m_regs [8];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_op(input logic [2:0] ra, input logic [2:0] rb, input logic src,
                          input logic [4:0] imm, input logic adc, input logic sub,
                          input logic sbb, input logic prec);
        Read_Addr_A = ra;
        Read_Addr_B = rb;
        Src_ALU_B   = src;
        imm5        = imm;
        ADC         = adc;
        SUB         = sub;
        SBB         = sbb;
        Pre_C       = prec;
    endtask

    task automatic push_lit(input logic [15:0] a, input logic [15:0] b, input logic [15:0] y,
                            input logic z, input logic n, input logic c, input logic v);
        sb_q.push_back('{outa: a, outb: b, y: y, z: z, n: n, c: c, v: v});
    endtask

    // Reference ALU written directly from the operation table.
    function automatic exp_t model(input logic [2:0] ra, input logic [2:0] rb, input logic src,
                                   input logic [4:0] imm, input logic adc, input logic sub,
                                   input logic sbb, input logic prec);
        exp_t        e;
        logic [15:0] a, bs, bx;
        logic        ci;
        logic [16:0] s;
        a  = m_regs[ra];
        bs = src ? {11'b0, imm} : m_regs[rb];
        if (sbb)      begin bx = ~bs; ci = ~prec; end
        else if (sub) begin bx = ~bs; ci = 1'b1;  end
        else if (adc) begin bx = bs;  ci = prec;  end
        else          begin bx = bs;  ci = 1'b0;  end
        s = {1'b0, a} + {1'b0, bx} + {16'b0, ci};
        e.outa = a;
        e.outb = m_regs[rb];
        e.y    = s[15:0];
        e.z    = (s[15:0] == 16'h0);
        e.n    = s[15];
        e.c    = s[16];
        e.v    = (a[15] == bx[15]) && (s[15] != a[15]);
        return e;
    endfunction

    task automatic sample();
        exp_t e;
        #2;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_empty: got 0 entries expected 1");
        end else begin
            e = sb_q.pop_front();
            check_eq("OutA", OutA, e.outa);
            check_eq("OutB", OutB, e.outb);
            check_eq("Y", Y, e.y);
            check_eq("Z", {15'b0, Z}, {15'b0, e.z});
            check_eq("N", {15'b0, N}, {15'b0, e.n});
            check_eq("C", {15'b0, C}, {15'b0, e.c});
            check_eq("V", {15'b0, V}, {15'b0, e.v});
        end
    endtask

    task automatic do_write(input logic [2:0] addr, input logic [15:0] data);
        Write_Addr = addr;
        Write_Data = data;
        Write_En   = 1'b1;
        @(posedge clk);
        #1;
        Write_En     = 1'b0;
        m_regs[addr] = data;
    endtask

    task automatic rand_vec();
        logic [2:0] ra, rb;
        logic       src, adc, sub, sbb, prec;
        logic [4:0] imm;
        ra   = 3'($urandom_range(0, 7));
        rb   = 3'($urandom_range(0, 7));
        src  = 1'($urandom);
        imm  = 5'($urandom);
        adc  = 1'($urandom);
        sub  = 1'($urandom);
        sbb  = 1'($urandom);
        prec = 1'($urandom);
        set_op(ra, rb, src, imm, adc, sub, sbb, prec);
        sb_q.push_back(model(ra, rb, src, imm, adc, sub, sbb, prec));
        sample();
    endtask

    initial begin
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
        set_op(3'd3, 3'd3, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Write attempted throughout reset must be blocked.
        clr        = 1'b1;
        Write_En   = 1'b1;
        Write_Addr = 3'd3;
        Write_Data = 16'hFFFF;
        #98;
        push_lit(16'h0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        sample();
        clr      = 1'b0;
        Write_En = 1'b0;
        push_lit(16'h0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        sample();

        do_write(3'd0, 16'h1234);
        do_write(3'd1, 16'h2345);
        set_op(3'd0, 3'd1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        push_lit(16'h1234, 16'h2345, 16'h3579, 1'b0, 1'b0, 1'b0, 1'b0); sample();
        set_op(3'd0, 3'd1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        push_lit(16'h1234, 16'h2345, 16'h3579, 1'b0, 1'b0, 1'b0, 1'b0); sample();
        set_op(3'd0, 3'd1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        push_lit(16'h1234, 16'h2345, 16'h357A, 1'b0, 1'b0, 1'b0, 1'b0); sample();
        set_op(3'd0, 3'd1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        push_lit(16'h1234, 16'h2345, 16'hEEEF, 1'b0, 1'b1, 1'b0, 1'b0); sample();
        set_op(3'd0, 3'd1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        push_lit(16'h1234, 16'h2345, 16'hEEEF, 1'b0, 1'b1, 1'b0, 1'b0); sample();
        set_op(3'd0, 3'd1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        push_lit(16'h1234, 16'h2345, 16'hEEEF, 1'b0, 1'b1, 1'b0, 1'b0); sample();
        set_op(3'd0, 3'd1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        push_lit(16'h1234, 16'h2345, 16'hEEEE, 1'b0, 1'b1, 1'b0, 1'b0); sample();
        // SBB outranks SUB and ADC when several op bits are set.
        set_op(3'd0, 3'd1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1);
        push_lit(16'h1234, 16'h2345, 16'hEEEE, 1'b0, 1'b1, 1'b0, 1'b0); sample();
        set_op(3'd0, 3'd1, 1'b1, 5'd10, 1'b0, 1'b0, 1'b0, 1'b0);
        push_lit(16'h1234, 16'h2345, 16'h123E, 1'b0, 1'b0, 1'b0, 1'b0); sample();

        do_write(3'd2, 16'h7FFF);
        do_write(3'd3, 16'h0001);
        set_op(3'd2, 3'd3, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        push_lit(16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1); sample();
        do_write(3'd3, 16'hFFFF);
        do_write(3'd4, 16'h0001);
        set_op(3'd3, 3'd4, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        push_lit(16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0); sample();

        // Write_En low: R0 keeps its value across an edge.
        Write_Addr = 3'd0;
        Write_Data = 16'hBEEF;
        Write_En   = 1'b0;
        @(posedge clk);
        #1;
        set_op(3'd0, 3'd1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        push_lit(16'h1234, 16'h2345, 16'h3579, 1'b0, 1'b0, 1'b0, 1'b0); sample();

        // Same-address write while reading R0.
        Write_Data = 16'h5555;
        Write_En   = 1'b1;
`ifdef RF_BYPASS_EN
        push_lit(16'h5555, 16'h2345, 16'h789A, 1'b0, 1'b0, 1'b0, 1'b0);
`else
        push_lit(16'h1234, 16'h2345, 16'h3579, 1'b0, 1'b0, 1'b0, 1'b0);
`endif
        sample();
        @(posedge clk);
        #1;
        Write_En  = 1'b0;
        m_regs[0] = 16'h5555;
        push_lit(16'h5555, 16'h2345, 16'h789A, 1'b0, 1'b0, 1'b0, 1'b0); sample();

        for (int k = 0; k < 24; k++) begin
            do_write(3'($urandom_range(0, 7)), 16'($urandom));
            rand_vec();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
